line_clear_sequencer: RTL and testbench

Sequences row elimination on the 20×10 Tetris playfield after each piece lock. The game-logic controller pulses `start` once the landed piece is merged into the playfield. The block then scans the rows bottom-up through a single row read/write port and compacts the surviving rows downward. It zero-fills the vacated top rows, reports the number of lines cleared and maintains the running score shown in the score display area.

---
 rtl/line_clear_sequencer_if.sv | 28 ++
 rtl/line_clear_sequencer.sv | 145 ++++++++++++++
 tb/tb_line_clear_sequencer.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/line_clear_sequencer_if.sv
// Single-port playfield row access bundle.
// The sequencer is the master; the playfield storage is the slave.
interface line_clear_sequencer_if #(
   parameter int ROW_AW = 5,
   parameter int COLS   = 10
);
   logic [ROW_AW-1:0] row_addr;
   logic [COLS-1:0]   row_rdata;
   logic              row_we;
   logic [ROW_AW-1:0] row_waddr;
   logic [COLS-1:0]   row_wdata;

   modport master (
      output row_addr,
      input  row_rdata,
      output row_we,
      output row_waddr,
      output row_wdata
   );

   modport slave (
      input  row_addr,
      output row_rdata,
      input  row_we,
      input  row_waddr,
      input  row_wdata
   );
endinterface

// File: rtl/line_clear_sequencer.sv
// Bottom-up full-row removal and compaction of the playfield, plus scoring.
// Build option: LINE_CLEAR_COMBO_SCORE_EN selects 0/1/3/5/8 combo points.
module line_clear_sequencer #(
   parameter int ROWS      = 20,
   parameter int COLS      = 10,
   parameter int ROW_AW    = 5,
   parameter int SCORE_W   = 14,
   parameter int SCORE_MAX = 9999
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic                   hold,
   line_clear_sequencer_if.master rp,
   output logic                   busy,
   output logic                   done,
   output logic [2:0]             lines_cleared,
   output logic [SCORE_W-1:0]     score
);

   typedef enum logic [1:0] {
      IDLE,
      SCAN,
      FILL,
      DONE
   } state_t;

   localparam logic [ROW_AW:0] PTR_TOP = (ROW_AW + 1)'(ROWS - 1);
   localparam logic [SCORE_W:0] SMAX   = (SCORE_W + 1)'(SCORE_MAX);

   state_t          state;
   logic [ROW_AW:0] rd;
   logic [ROW_AW:0] wr;
   logic [ROW_AW:0] cnt;
   logic [ROW_AW:0] cnt_nxt;
   logic            full;
   logic [SCORE_W:0] sum;

   function automatic logic [SCORE_W:0] points(input logic [ROW_AW:0] n);
      logic [SCORE_W:0] p;
`ifdef LINE_CLEAR_COMBO_SCORE_EN
      unique case (1'b1)
         (n == 0): p = (SCORE_W + 1)'(0);
         (n == 1): p = (SCORE_W + 1)'(1);
         (n == 2): p = (SCORE_W + 1)'(3);
         (n == 3): p = (SCORE_W + 1)'(5);
         default:  p = (SCORE_W + 1)'(8);
      endcase
`else
      p = (SCORE_W + 1)'(n);
`endif
      return p;
   endfunction

   assign full    = &rp.row_rdata;
   assign cnt_nxt = cnt + {{ROW_AW{1'b0}}, full};
   assign sum     = {1'b0, score} + points(cnt);

   // Row port: read in SCAN, copy survivors or zero-fill; silenced by reset
   always_comb begin
      rp.row_addr  = '0;
      rp.row_we    = 1'b0;
      rp.row_waddr = '0;
      rp.row_wdata = '0;
      if (!reset) begin
         unique case (state)
            SCAN: begin
               rp.row_addr = rd[ROW_AW-1:0];
               if (!hold && !full) begin
                  rp.row_we    = (rd != wr);
                  rp.row_waddr = wr[ROW_AW-1:0];
                  rp.row_wdata = rp.row_rdata;
               end
            end
            FILL: begin
               if (!hold) begin
                  rp.row_we    = 1'b1;
                  rp.row_waddr = wr[ROW_AW-1:0];
               end
            end
            default: ;
         endcase
      end
   end

   // Pass sequencing, pointers, and registered status/score outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         rd            <= '0;
         wr            <= '0;
         cnt           <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
         lines_cleared <= '0;
         score         <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  state <= SCAN;
                  rd    <= PTR_TOP;
                  wr    <= PTR_TOP;
                  cnt   <= '0;
                  busy  <= 1'b1;
               end
            end
            SCAN: begin
               if (!hold) begin
                  rd  <= rd - 1'b1;
                  cnt <= cnt_nxt;
                  if (!full) wr <= wr - 1'b1;
                  if (rd == '0) begin
                     if (cnt_nxt != '0) begin
                        state <= FILL;
                     end else begin
                        state <= DONE;
                        done  <= 1'b1;
                     end
                  end
               end
            end
            FILL: begin
               if (!hold) begin
                  wr <= wr - 1'b1;
                  if (wr == '0) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end
               end
            end
            DONE: begin
               state         <= IDLE;
               busy          <= 1'b0;
               done          <= 1'b0;
               lines_cleared <= (cnt > 7) ? 3'd7 : cnt[2:0];
               score         <= (sum > SMAX) ? SMAX[SCORE_W-1:0]
                                             : sum[SCORE_W-1:0];
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_line_clear_sequencer.sv
// Scoreboarded bench for line_clear_sequencer with a behavioural playfield.
// Expected writes are queued per pass and popped as the DUT writes.
module tb_line_clear_sequencer;
   localparam int ROWS      = 20;
   localparam int COLS      = 10;
   localparam int ROW_AW    = 5;
   localparam int SCORE_W   = 14;
   localparam int SCORE_MAX = 9999;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic start = 1'b0;
   logic hold = 1'b0;
   logic busy;
   logic done;
   logic [2:0] lines_cleared;
   logic [SCORE_W-1:0] score;

   line_clear_sequencer_if #(.ROW_AW(ROW_AW), .COLS(COLS)) rif ();

   line_clear_sequencer #(
      .ROWS(ROWS), .COLS(COLS), .ROW_AW(ROW_AW),
      .SCORE_W(SCORE_W), .SCORE_MAX(SCORE_MAX)
   ) dut (
      .clk(clk),
      .reset(reset),
      .start(start),
      .hold(hold),
      .rp(rif.master),
      .busy(busy),
      .done(done),
      .lines_cleared(lines_cleared),
      .score(score)
   );

   always #5 clk = ~clk;

   logic [COLS-1:0] pf  [ROWS];
   logic [COLS-1:0] pat [ROWS];
   logic [COLS-1:0] fin [ROWS];
   logic load = 1'b0;
   logic [ROW_AW+COLS-1:0] wq[$];
   int n_run = 0;
   int n_fail = 0;
   int sm = 0;

   assign rif.row_rdata = pf[rif.row_addr];

   // Playfield storage: bench preload or DUT write at the clock edge
   always @(posedge clk) begin
      if (load) begin
         for (int i = 0; i < ROWS; i++) pf[i] <= pat[i];
      end else if (rif.row_we) begin
         pf[rif.row_waddr] <= rif.row_wdata;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Write monitor: every strobe must match the head of the queue
   always @(negedge clk) begin
      logic [ROW_AW+COLS-1:0] e;
      if (rif.row_we === 1'b1) begin
         if (wq.size() == 0) begin
            chk("wr_extra", {22'd0, rif.row_wdata}, 32'hFFFF_FFFF);
         end else begin
            e = wq.pop_front();
            chk("wr_addr", 32'(rif.row_waddr), 32'(e[ROW_AW+COLS-1:COLS]));
            chk("wr_data", 32'(rif.row_wdata), 32'(e[COLS-1:0]));
         end
      end
      if (hold && busy && !done) chk("hold_we", 32'(rif.row_we), 0);
   end

   function automatic int pts(input int c);
`ifdef LINE_CLEAR_COMBO_SCORE_EN
      if (c == 0) return 0;
      if (c == 1) return 1;
      if (c == 2) return 3;
      if (c == 3) return 5;
      return 8;
`else
      return c;
`endif
   endfunction

   task automatic build_model(output int c);
      int w;
      c = 0;
      w = ROWS - 1;
      for (int r = ROWS - 1; r >= 0; r--) begin
         if (&pat[r]) begin
            c++;
         end else begin
            if (r != w) wq.push_back({ROW_AW'(w), pat[r]});
            fin[w] = pat[r];
            w--;
         end
      end
      for (int f = w; f >= 0; f--) begin
         wq.push_back({ROW_AW'(f), COLS'(0)});
         fin[f] = '0;
      end
   endtask

   task automatic load_pf;
      @(posedge clk); #1 load = 1'b1;
      @(posedge clk); #1 load = 1'b0;
   endtask

   task automatic clr_pat;
      for (int i = 0; i < ROWS; i++) pat[i] = '0;
   endtask

   task automatic run_pass(input int h_at, input int h_len, input bit rep);
      int c;
      int k;
      int bad;
      int exp_k;
      bit seen;
      load_pf();
      build_model(c);
      exp_k = ROWS + c + 1 + h_len;
      start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      k = 1;
      seen = 1'b0;
      while (!seen && k < 400) begin
         hold = (k >= h_at) && (k < h_at + h_len);
         start = rep && (k == 3);
         @(negedge clk);
         if (done) begin
            seen = 1'b1;
            chk("done_cyc", k, exp_k);
         end else begin
            @(posedge clk); #1;
            k++;
         end
      end
      if (!seen) chk("done_timeout", 0, 1);
      hold = 1'b0;
      start = 1'b0;
      sm = (sm + pts(c) > SCORE_MAX) ? SCORE_MAX : sm + pts(c);
      @(posedge clk); #1;
      @(negedge clk);
      chk("done_pulse", 32'(done), 0);
      chk("busy_end", 32'(busy), 0);
      chk("lines", 32'(lines_cleared), (c > 7) ? 7 : c);
      chk("score", 32'(score), sm);
      chk("wq_left", wq.size(), 0);
      bad = 0;
      for (int r = 0; r < ROWS; r++) if (pf[r] !== fin[r]) bad++;
      chk("pf_rows", bad, 0);
      if (rep) begin
         repeat (3) @(negedge clk);
         chk("requeue", 32'(busy), 0);
      end
      wq.delete();
   endtask

   task automatic chk_zero_outs(input string tag);
      chk({tag, "_busy"}, 32'(busy), 0);
      chk({tag, "_done"}, 32'(done), 0);
      chk({tag, "_we"}, 32'(rif.row_we), 0);
      chk({tag, "_addr"}, 32'(rif.row_addr), 0);
      chk({tag, "_waddr"}, 32'(rif.row_waddr), 0);
      chk({tag, "_wdata"}, 32'(rif.row_wdata), 0);
      chk({tag, "_lines"}, 32'(lines_cleared), 0);
      chk({tag, "_score"}, 32'(score), 0);
   endtask

   initial begin
      int c;
      int k;
      int guard;
      for (int i = 0; i < ROWS; i++) pf[i] = '0;
      clr_pat();
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      chk_zero_outs("rst");
      @(posedge clk); #1 reset = 1'b0;

      // empty playfield
      clr_pat();
      run_pass(0, 0, 1'b0);

      // one full row at the bottom
      clr_pat();
      pat[19] = '1;
      pat[18] = 10'b0000001111;
      run_pass(0, 0, 1'b0);

      // four full rows
      clr_pat();
      for (int i = 16; i < 20; i++) pat[i] = '1;
      pat[15] = 10'b1000000000;
      run_pass(0, 0, 1'b0);

      // interleaved full rows
      clr_pat();
      pat[19] = '1;
      pat[18] = 10'b0101010101;
      pat[17] = '1;
      pat[16] = 10'b0011001100;
      run_pass(0, 0, 1'b0);

      // hold mid-scan and a start pulse while busy
      clr_pat();
      pat[10] = '1;
      pat[19] = 10'b1111100000;
      pat[12] = 10'b0000011111;
      pat[3]  = 10'b1010000001;
      run_pass(5, 5, 1'b1);

      // random mixes
      for (int p = 0; p < 4; p++) begin
         for (int i = 0; i < ROWS; i++) begin
            if ($urandom_range(0, 3) == 0) begin
               pat[i] = '1;
            end else begin
               pat[i] = COLS'($urandom);
               if (&pat[i]) pat[i][0] = 1'b0;
            end
         end
         run_pass(0, 0, 1'b0);
      end

      // drive score into saturation
      guard = 0;
      while (sm < SCORE_MAX - 20 && guard < 3000) begin
         for (int i = 0; i < ROWS; i++) pat[i] = '1;
         run_pass(0, 0, 1'b0);
         guard++;
      end
      while (sm < SCORE_MAX && guard < 3100) begin
         clr_pat();
         for (int i = 16; i < 20; i++) pat[i] = '1;
         run_pass(0, 0, 1'b0);
         guard++;
      end
      chk("sat_reach", sm, SCORE_MAX);
      clr_pat();
      for (int i = 16; i < 20; i++) pat[i] = '1;
      run_pass(0, 0, 1'b0);

      // reset during FILL
      for (int i = 0; i < ROWS; i++) begin
         pat[i] = COLS'($urandom) & 10'h3FE;
      end
      for (int i = 16; i < 20; i++) pat[i] = '1;
      load_pf();
      build_model(c);
      repeat (c) void'(wq.pop_back());
      start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      k = 1;
      while (k < ROWS + 1) begin
         @(posedge clk); #1;
         k++;
      end
      reset = 1'b1;
      @(negedge clk);
      chk("rstfill_we", 32'(rif.row_we), 0);
      @(posedge clk); #1;
      @(negedge clk);
      chk_zero_outs("rstfill");
      @(posedge clk); #1 reset = 1'b0;
      repeat (30) @(posedge clk);
      #1;
      chk("rstfill_wq", wq.size(), 0);
      chk("rstfill_idle", 32'(busy), 0);
      wq.delete();
      sm = 0;

      // reset and start together
      reset = 1'b1;
      start = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      start = 1'b0;
      @(negedge clk);
      chk("rst_start", 32'(busy), 0);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule
